if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Generates the fetch PC and chip-enable for the combinational instruction ROM.
- Applies branch redirects, exception flush and pipeline stalls.
- Registers the returned instruction and its PC into the IF/ID pipeline latch that feeds decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and held while rom_ce_o is low.
- STALL_W, 6, width of the stall vector from the pipeline controller (bit 0 = PC, bit 1 = IF, bit 2 = ID).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset; synchronous, active-high.
- stall  input  STALL_W  per-stage hold request from ctrl.
- flush  input  1  exception flush; redirect to new_pc and clear the IF/ID latch.
- new_pc  input  32  exception handler / ERET target, valid when flush=1.
- branch_flag_i  input  1  taken branch/jump resolved in ID.
- branch_target_address_i  input  32  redirect target, valid with branch_flag_i.
- inst_i  input  32  instruction word returned combinationally by the ROM for rom_addr_o.
- rom_addr_o  output  32  fetch PC (byte address, word aligned).
- rom_ce_o  output  1  ROM chip enable.
- id_pc  output  32  PC of the instruction presented to decode.
- id_inst  output  32  instruction presented to decode.

Behaviour:
- All state updates on the rising edge of clk.
- Reset (rst=1):
  - rom_ce_o=0, rom_addr_o=RESET_PC, id_pc=0, id_inst=0.
  - Reset takes effect at the edge, independent of every other input.
- rom_ce_o is registered from ~rst. It first reads 1 in the cycle after the first edge with rst=0.
- PC update, evaluated at each edge, in priority order:
  1. rom_ce_o==0 → RESET_PC.
  2. flush → new_pc.
  3. stall[0]==1 → hold.
  4. branch_flag_i → branch_target_address_i.
  5. Otherwise → PC+4.
- Loaded targets have bits [1:0] forced to 0. No alignment exception is raised here.
- PC+4 wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- flush overrides stall: a stalled PC still takes new_pc.
- branch_flag_i while stall[0]=1 is ignored. ctrl keeps the branch asserted until the stall releases.
- IF/ID latch update, evaluated at each edge, in priority order:
  1. rst or flush → id_pc=0, id_inst=0.
  2. stall[1]==1 && stall[2]==0 → bubble: id_pc=0, id_inst=0 (NOP).
  3. stall[1]==0 → id_pc=rom_addr_o, id_inst=inst_i.
  4. Otherwise → hold.
- When rom_ce_o==0 the ROM returns zero, so the latch captures PC=RESET_PC with inst=0 (a NOP).
- Latency: the instruction at PC X appears on id_inst exactly one cycle after rom_addr_o==X, when unstalled.
- Branch delay slot:
  - The instruction fetched in the cycle branch_flag_i is asserted is the delay slot.
  - It is latched normally, not squashed.
  - The next rom_addr_o equals the target.
- Simultaneous flush and branch_flag_i: flush wins on both PC and latch.
- Mid-operation reset: same as power-on reset.
  - rom_ce_o drops at that edge.
  - The PC refetches from RESET_PC once ce returns.
- stall is assumed monotone (stall[n]=1 implies stall[n-1]=1). Non-monotone patterns are undefined and not checked.

Decomposition:
- Shared defines file (existing global header) holds:
  - bus-width macros InstAddrBus and InstBus;
  - ZeroWord;
  - ChipEnable/ChipDisable;
  - Stop/NoStop;
  - Branch/NotBranch.
- No new package is needed; add RESET_PC as a parameter only.
- One natural sub-module: pc_reg, containing the PC plus ce logic.
- The IF/ID latch stays in if_stage.

Test Plan:
- Reset held 3 cycles, then released → rom_ce_o=0 during reset and 1 one cycle after release. rom_addr_o sequence is 0,0,4,8. id_inst is 0 then tracks inst_i with one-cycle lag.
- branch_flag_i=1 with target 32'h0000_0103 while PC=0x10 → next PC is 0x100, bits [1:0] cleared. The instruction at 0x10 (delay slot) still appears on id_inst.
- stall=6'b000011 for 2 cycles at PC=0x20 → PC holds at 0x20. id_pc/id_inst are 0 (bubble) for 2 cycles, then resume with 0x20's instruction.
- stall=6'b000111 for 2 cycles → PC and the IF/ID latch both hold their prior values unchanged.
- flush=1 with new_pc=0x0000_0040 while stall=6'b000111 and branch_flag_i=1 → next PC=0x40 and id_inst=0. The branch is ignored.
- Force PC to 0xFFFF_FFFC via flush/new_pc, then run unstalled → next rom_addr_o=0x0000_0000 (wrap). id_pc shows 0xFFFF_FFFC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared widths and named constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD    = INST_W'(0);
  localparam logic [INST_ADDR_W-1:0] ZERO_ADDR    = INST_ADDR_W'(0);
  localparam logic [INST_ADDR_W-1:0] PC_STEP      = INST_ADDR_W'(4);

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic BRANCH       = 1'b1;

  // Fetch addresses are word aligned; low two bits are simply dropped.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter and ROM chip-enable for the fetch stage.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_pc,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  output logic [INST_ADDR_W-1:0] pc,
  output logic                   ce
);

  // Chip enable follows ~rst one edge late, so the first fetch is at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce <= CHIP_DISABLE;
    end else begin
      ce <= CHIP_ENABLE;
    end
  end

  // PC priority: disabled, flush, stall hold, branch, sequential (wraps mod 2^32).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (ce == CHIP_DISABLE) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= word_align(new_pc);
    end else if (stall_pc == STOP) begin
      pc <= pc;
    end else if (branch_flag == BRANCH) begin
      pc <= word_align(branch_target);
    end else begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation plus the IF/ID pipeline latch.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned            STALL_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  input  logic [INST_W-1:0]      inst_i,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  output logic                   rom_ce_o,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst
);

  // Only the PC, IF and ID stall bits matter to this stage.
  logic [STALL_W-1:3] unused_stall;
  assign unused_stall = stall[STALL_W-1:3];

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (stall[0]),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag_i),
    .branch_target (branch_target_address_i),
    .pc            (rom_addr_o),
    .ce            (rom_ce_o)
  );

  // IF/ID latch: clear on reset/flush, bubble when IF stalls but ID runs, else capture or hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc   <= ZERO_ADDR;
      id_inst <= ZERO_WORD;
    end else if ((stall[1] == STOP) && (stall[2] == NO_STOP)) begin
      id_pc   <= ZERO_ADDR;
      id_inst <= ZERO_WORD;
    end else if (stall[1] == NO_STOP) begin
      id_pc   <= rom_addr_o;
      id_inst <= inst_i;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table plus randomized run vs. a reference model.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] inst_i;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .STALL_W  (6)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .inst_i                  (inst_i),
    .rom_addr_o              (rom_addr_o),
    .rom_ce_o                (rom_ce_o),
    .id_pc                   (id_pc),
    .id_inst                 (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synthetic ROM contents: a distinct, nonzero word per address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  // ROM is combinational and returns zero while disabled.
  assign inst_i = (rom_ce_o === 1'b1) ? rom_word(rom_addr_o) : 32'h0;

  // Reference model state.
  logic        m_ce;
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;

  // Advance the model by one clock edge using the behavioural rules.
  task automatic model_step(input logic r, input logic [5:0] s, input logic f,
                            input logic [31:0] npc, input logic b, input logic [31:0] tgt);
    logic [31:0] cur_pc;
    logic [31:0] cur_inst;
    logic        cur_ce;
    cur_pc   = m_pc;
    cur_ce   = m_ce;
    cur_inst = cur_ce ? rom_word(cur_pc) : 32'h0;
    if (r) begin
      m_ce = 1'b0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0;
    end else begin
      m_ce = 1'b1;
      if (!cur_ce)    m_pc = 32'h0;
      else if (f)     m_pc = npc & ~32'd3;
      else if (s[0])  m_pc = cur_pc;
      else if (b)     m_pc = tgt & ~32'd3;
      else            m_pc = cur_pc + 32'd4;
      if (f || (s[1] && !s[2])) begin
        m_id_pc = 32'h0; m_id_inst = 32'h0;
      end else if (!s[1]) begin
        m_id_pc = cur_pc; m_id_inst = cur_inst;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, clock once, then sample 1 time unit after the rise.
  task automatic apply(input logic r, input logic [5:0] s, input logic f,
                       input logic [31:0] npc, input logic b, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; stall = s; flush = f; new_pc = npc;
    branch_flag_i = b; branch_target_address_i = tgt;
    @(posedge clk);
    #1;
    model_step(r, s, f, npc, b, tgt);
  endtask

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic        e_ce;
    logic [31:0] e_id_pc;
    logic [31:0] e_id_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] s, input logic f, input logic [31:0] npc,
                     input logic b, input logic [31:0] tgt, input logic [31:0] ea, input logic ec,
                     input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.new_pc = npc; v.br = b; v.tgt = tgt;
    v.e_addr = ea; v.e_ce = ec; v.e_id_pc = ep; v.e_id_inst = ei;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0;
    m_ce = 1'b0; m_pc = '0; m_id_pc = '0; m_id_inst = '0;

    //   rst stall    fl new_pc        br tgt           addr          ce id_pc         id_inst
    // reset for 3 cycles, then release
    add(1, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0);
    add(1, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0);
    add(1, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0);
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        32'h0);
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0,        rom_word(32'h0));
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h8,        1, 32'h4,        rom_word(32'h4));
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'hC,        1, 32'h8,        rom_word(32'h8));
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h10,       1, 32'hC,        rom_word(32'hC));
    // branch at PC 0x10 to unaligned 0x103; delay slot 0x10 still latched
    add(0, 6'b000000, 0, 32'h0,        1, 32'h103,      32'h100,      1, 32'h10,       rom_word(32'h10));
    add(0, 6'b000000, 0, 32'h0,        1, 32'h20,       32'h20,       1, 32'h100,      rom_word(32'h100));
    // IF stalled, ID running: PC holds, bubble twice, then resume
    add(0, 6'b000011, 0, 32'h0,        0, 32'h0,        32'h20,       1, 32'h0,        32'h0);
    add(0, 6'b000011, 0, 32'h0,        0, 32'h0,        32'h20,       1, 32'h0,        32'h0);
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h24,       1, 32'h20,       rom_word(32'h20));
    // IF and ID stalled: everything holds
    add(0, 6'b000111, 0, 32'h0,        0, 32'h0,        32'h24,       1, 32'h20,       rom_word(32'h20));
    add(0, 6'b000111, 0, 32'h0,        0, 32'h0,        32'h24,       1, 32'h20,       rom_word(32'h20));
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h28,       1, 32'h24,       rom_word(32'h24));
    // flush beats stall and branch
    add(0, 6'b000111, 1, 32'h40,       1, 32'h200,      32'h40,       1, 32'h0,        32'h0);
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h44,       1, 32'h40,       rom_word(32'h40));
    // flush to top of memory (unaligned), then wrap
    add(0, 6'b000000, 1, 32'hFFFF_FFFE, 0, 32'h0,       32'hFFFF_FFFC, 1, 32'h0,       32'h0);
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC));
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0,        rom_word(32'h0));
    // mid-operation reset overrides flush/branch
    add(1, 6'b000001, 1, 32'h80,       1, 32'h90,       32'h0,        0, 32'h0,        32'h0);
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        32'h0);
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0,        rom_word(32'h0));
    // PC-only stall: PC holds, latch keeps capturing, branch ignored until release
    add(0, 6'b000001, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h4,        rom_word(32'h4));
    add(0, 6'b000001, 0, 32'h0,        1, 32'h80,       32'h4,        1, 32'h4,        rom_word(32'h4));
    add(0, 6'b000000, 0, 32'h0,        1, 32'h80,       32'h80,       1, 32'h4,        rom_word(32'h4));
    add(0, 6'b000000, 0, 32'h0,        0, 32'h0,        32'h84,       1, 32'h80,       rom_word(32'h80));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].new_pc, vecs[i].br, vecs[i].tgt);
      chk($sformatf("vec%0d.rom_addr", i), rom_addr_o, vecs[i].e_addr);
      chk($sformatf("vec%0d.rom_ce", i), 32'(rom_ce_o), 32'(vecs[i].e_ce));
      chk($sformatf("vec%0d.id_pc", i), id_pc, vecs[i].e_id_pc);
      chk($sformatf("vec%0d.id_inst", i), id_inst, vecs[i].e_id_inst);
    end

    // Randomized run with monotone stall patterns against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  s;
      int unsigned lvl;
      lvl = $urandom_range(0, 8);
      s = (lvl >= 6) ? 6'b000000 : 6'((7'd1 << lvl) - 7'd1);
      apply(($urandom_range(0, 39) == 0), s, ($urandom_range(0, 9) == 0), $urandom,
            ($urandom_range(0, 3) == 0), $urandom);
      chk($sformatf("rnd%0d.rom_addr", n), rom_addr_o, m_pc);
      chk($sformatf("rnd%0d.rom_ce", n), 32'(rom_ce_o), 32'(m_ce));
      chk($sformatf("rnd%0d.id_pc", n), id_pc, m_id_pc);
      chk($sformatf("rnd%0d.id_inst", n), id_inst, m_id_inst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
